// File: rtl/seq_tx_if.sv
// Serial test-pattern transmitter bundle: switch/button controls in, serial bit and display status out.
// The master side drives load/pattern/step/rpt; the transmitter (slave) drives everything else.
interface seq_tx_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
);
  logic             load;
  logic [WIDTH-1:0] pattern;
  logic             step;
  logic             rpt;
  logic             dout;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bit_idx;
  logic [3:0]       frames;
  logic [WIDTH-1:0] shreg;
  logic [1:0]       st;

  modport master (
    output load, pattern, step, rpt,
    input  dout, busy, done, bit_idx, frames, shreg, st
  );

  modport slave (
    input  load, pattern, step, rpt,
    output dout, busy, done, bit_idx, frames, shreg, st
  );
endinterface

// File: rtl/seq_tx.sv
// Shifts a loaded pattern out MSB first, one bit per rising edge of step; new bit visible one clk after the edge.
// No backpressure: load wins over step, step is ignored outside SEND, and all outputs come from registers.
module seq_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  seq_tx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           st_q, st_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] saved_q, saved_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [3:0]       frames_q, frames_d;
  logic             step_q;
  logic             step_rise;

  assign step_rise = bus.step & ~step_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= IDLE;
      shreg_q  <= '0;
      saved_q  <= '0;
      idx_q    <= '0;
      frames_q <= '0;
      step_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      shreg_q  <= shreg_d;
      saved_q  <= saved_d;
      idx_q    <= idx_d;
      frames_q <= frames_d;
      step_q   <= bus.step;
    end
  end

  always_comb begin
    st_d     = st_q;
    shreg_d  = shreg_q;
    saved_d  = saved_q;
    idx_d    = idx_q;
    frames_d = frames_q;
    case (st_q)
      IDLE, DONE: begin
        if (bus.load) begin
          shreg_d = bus.pattern;
          saved_d = bus.pattern;
          idx_d   = '0;
          st_d    = SEND;
        end
      end
      SEND: begin
        if (bus.load) begin
          shreg_d = bus.pattern;
          saved_d = bus.pattern;
          idx_d   = '0;
        end else if (step_rise) begin
          if (idx_q == LAST_IDX) begin
            frames_d = frames_q + 4'd1;
            idx_d    = '0;
            // Repeat restarts from the saved copy, not the live switches.
            if (bus.rpt) begin
              shreg_d = saved_q;
            end else begin
              shreg_d = '0;
              st_d    = DONE;
            end
          end else begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            idx_d   = idx_q + CNT_W'(1);
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  assign bus.dout    = (st_q == SEND) ? shreg_q[WIDTH-1] : 1'b0;
  assign bus.busy    = (st_q == SEND);
  assign bus.done    = (st_q == DONE);
  assign bus.bit_idx = idx_q;
  assign bus.frames  = frames_q;
  assign bus.shreg   = shreg_q;
  assign bus.st      = st_q;

endmodule

// File: tb/tb_seq_tx.sv
// Directed bench for seq_tx: a vector table for the basic frame plus hand sequences for the corner cases.
module tb_seq_tx;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  seq_tx_if #(.WIDTH(8), .CNT_W(3)) bus ();

  seq_tx #(.WIDTH(8), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [7:0] pat;
    logic       pulse;
    logic       exp_dout;
    logic [2:0] exp_idx;
    logic [1:0] exp_st;
    logic [3:0] exp_frames;
    logic [7:0] exp_shreg;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] p);
    bus.pattern = p;
    bus.load    = 1'b1;
    tick();
    bus.load    = 1'b0;
  endtask

  task automatic pulse();
    bus.step = 1'b1;
    repeat (4) tick();
    bus.step = 1'b0;
    repeat (4) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " st"},     16'(bus.st), 16'd0);
    check({tag, " dout"},   16'(bus.dout), 16'd0);
    check({tag, " busy"},   16'(bus.busy), 16'd0);
    check({tag, " done"},   16'(bus.done), 16'd0);
    check({tag, " idx"},    16'(bus.bit_idx), 16'd0);
    check({tag, " frames"}, 16'(bus.frames), 16'd0);
    check({tag, " shreg"},  16'(bus.shreg), 16'd0);
  endtask

  initial begin
    logic [7:0] pat;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.load    = 1'b0;
    bus.pattern = 8'h00;
    bus.step    = 1'b0;
    bus.rpt     = 1'b0;

    //         ld    pat    pulse dout idx  st  fr  shreg
    vecs[0] = '{1'b1, 8'hB6, 1'b0, 1'b1, 3'd0, 2'd1, 4'd0, 8'hB6};
    vecs[1] = '{1'b0, 8'hB6, 1'b1, 1'b0, 3'd1, 2'd1, 4'd0, 8'h6C};
    vecs[2] = '{1'b0, 8'hB6, 1'b1, 1'b1, 3'd2, 2'd1, 4'd0, 8'hD8};
    vecs[3] = '{1'b0, 8'hB6, 1'b1, 1'b1, 3'd3, 2'd1, 4'd0, 8'hB0};
    vecs[4] = '{1'b0, 8'hB6, 1'b1, 1'b0, 3'd4, 2'd1, 4'd0, 8'h60};
    vecs[5] = '{1'b0, 8'hB6, 1'b1, 1'b1, 3'd5, 2'd1, 4'd0, 8'hC0};
    vecs[6] = '{1'b0, 8'hB6, 1'b1, 1'b1, 3'd6, 2'd1, 4'd0, 8'h80};
    vecs[7] = '{1'b0, 8'hB6, 1'b1, 1'b0, 3'd7, 2'd1, 4'd0, 8'h00};
    vecs[8] = '{1'b0, 8'hB6, 1'b1, 1'b0, 3'd0, 2'd2, 4'd1, 8'h00};
    vecs[9] = '{1'b0, 8'hB6, 1'b1, 1'b0, 3'd0, 2'd2, 4'd1, 8'h00};

    // Reset state
    do_reset(2);
    check_reset_vals("reset");

    // Basic send, then a step in DONE that must be ignored
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].ld) do_load(vecs[i].pat);
      if (vecs[i].pulse) pulse();
      check($sformatf("vec%0d dout", i),   16'(bus.dout), 16'(vecs[i].exp_dout));
      check($sformatf("vec%0d idx", i),    16'(bus.bit_idx), 16'(vecs[i].exp_idx));
      check($sformatf("vec%0d st", i),     16'(bus.st), 16'(vecs[i].exp_st));
      check($sformatf("vec%0d busy", i),   16'(bus.busy), 16'(vecs[i].exp_st == 2'd1));
      check($sformatf("vec%0d done", i),   16'(bus.done), 16'(vecs[i].exp_st == 2'd2));
      check($sformatf("vec%0d frames", i), 16'(bus.frames), 16'(vecs[i].exp_frames));
      check($sformatf("vec%0d shreg", i),  16'(bus.shreg), 16'(vecs[i].exp_shreg));
    end

    // Step held high for 20 clks advances once
    do_reset(1);
    do_load(8'hB6);
    bus.step = 1'b1;
    repeat (20) tick();
    check("held idx",   16'(bus.bit_idx), 16'd1);
    check("held shreg", 16'(bus.shreg), 16'h6C);
    bus.step = 1'b0;
    tick();

    // Repeat mode: A5 streamed twice
    do_reset(1);
    bus.rpt = 1'b1;
    pat = 8'hA5;
    do_load(pat);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("rpt bit%0d dout", i), 16'(bus.dout), 16'(pat[7 - (i % 8)]));
      check($sformatf("rpt bit%0d idx", i),  16'(bus.bit_idx), 16'(i % 8));
      pulse();
    end
    check("rpt st",     16'(bus.st), 16'd1);
    check("rpt frames", 16'(bus.frames), 16'd2);
    check("rpt idx",    16'(bus.bit_idx), 16'd0);
    check("rpt shreg",  16'(bus.shreg), 16'hA5);

    // Load and step_rise in the same cycle at bit_idx 5
    repeat (5) pulse();
    check("ldstep pre idx", 16'(bus.bit_idx), 16'd5);
    bus.pattern = 8'hF0;
    bus.load    = 1'b1;
    bus.step    = 1'b1;
    tick();
    bus.load    = 1'b0;
    check("ldstep idx",    16'(bus.bit_idx), 16'd0);
    check("ldstep shreg",  16'(bus.shreg), 16'hF0);
    check("ldstep dout",   16'(bus.dout), 16'd1);
    check("ldstep frames", 16'(bus.frames), 16'd2);
    bus.step = 1'b0;
    repeat (2) tick();
    bus.rpt = 1'b0;

    // Reset mid-frame at bit_idx 3, then steps without load do nothing
    repeat (3) pulse();
    check("midrst pre idx", 16'(bus.bit_idx), 16'd3);
    do_reset(1);
    check_reset_vals("midrst");
    repeat (2) pulse();
    check_reset_vals("midrst steps");

    // Pattern change after load must not alter the frame
    pat = 8'h81;
    do_load(pat);
    bus.pattern = 8'h00;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("patchg bit%0d", i), 16'(bus.dout), 16'(pat[7 - i]));
      pulse();
    end
    check("patchg st",     16'(bus.st), 16'd2);
    check("patchg frames", 16'(bus.frames), 16'd1);
    check("patchg dout",   16'(bus.dout), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_tx.md
Name: seq_tx

Overview:
Serial test-pattern transmitter: the stimulus side of the sequence detector. It loads a WIDTH-bit pattern from switches and presents it one bit at a time on dout, MSB first, advancing one bit per rising edge of a step input (a debounced button). Optional repeat mode streams the pattern continuously. It also exports the state, bit index and frame count for LEDs and the 7-segment display.

Parameters:
WIDTH, 8, pattern length in bits (2..16)
CNT_W, 3, bit index width; must equal clog2(WIDTH)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
load  input  1  level; captures pattern and starts a frame, sampled every clk
pattern  input  WIDTH  pattern to transmit, MSB sent first
step  input  1  level (debounced); each 0->1 transition advances one bit
rpt  input  1  1 = restart the pattern after the last bit; 0 = stop
dout  output  1  current serial bit; drives the detector's din
busy  output  1  high while a frame is in progress (SEND)
done  output  1  high in DONE state
bit_idx  output  CNT_W  index of the bit on dout, 0 = MSB
frames  output  4  completed frames, wraps 15->0
shreg  output  WIDTH  remaining bits, for the LED mirror
st  output  2  state code: IDLE=0, SEND=1, DONE=2

Behaviour:
- All state changes occur on posedge clk. Reset is synchronous and active-high; it overrides every other input.
- Reset values:
  - st=IDLE; dout=0, busy=0, done=0
  - bit_idx=0, frames=0, shreg=0
  - saved pattern=0; step_q=0
- Edge detect:
  - step_q is a registered copy of step.
  - step_rise = step & ~step_q, evaluated combinationally in the same cycle.
  - A step held high produces exactly one advance.
- dout = shreg[WIDTH-1] in SEND, 0 otherwise. busy = (st==SEND). done = (st==DONE). All are registered or decoded from registered state, with no input-to-output combinational path.
- IDLE:
  - load=1: shreg<=pattern, saved<=pattern, bit_idx<=0, go to SEND.
  - step is ignored.
- SEND:
  - load=1 has priority over step_rise. It restarts the frame exactly as in IDLE; frames is unchanged.
  - step_rise with bit_idx<WIDTH-1: shreg<=shreg<<1 with zero fill, bit_idx<=bit_idx+1.
  - step_rise with bit_idx==WIDTH-1: frames<=frames+1 (mod 16), then:
    - rpt=1: shreg<=saved, bit_idx<=0, stay in SEND.
    - rpt=0: shreg<=0, bit_idx<=0, go to DONE.
  - Latency: the new dout is visible the first clk after the cycle in which step_rise is high. The bit consumed by the detector is the dout value before the edge.
- DONE:
  - dout=0.
  - load=1: reload as in IDLE and go to SEND.
  - step is ignored.
  - Only rst returns the block to IDLE.
- pattern changes while in SEND have no effect until the next load. The saved copy is used for repeats.
- rpt is sampled only at the last-bit step.
- Reset mid-frame: the frame is abandoned with no partial frames increment.
- st encoding 3 is unused. It decodes as IDLE on the next clk as a safe recovery.

Test Plan:
- Reset and basic send: rst 2 clks, pattern=8'b1011_0110, load 1 clk, 8 step pulses 4 clks wide. Required: dout sequence 1,0,1,1,0,1,1,0; bit_idx 0..7; after the 8th pulse st=DONE, done=1, dout=0, frames=1.
- Step held high: step high for 20 clks in SEND. Required: exactly one advance (bit_idx 0->1), and shreg shifted once.
- Repeat wrap: rpt=1, pattern=8'hA5, 16 step pulses. Required: dout = 1010_0101 repeated twice, st stays SEND, frames=2, bit_idx back to 0.
- Load and step in the same cycle at bit_idx=5: pattern=8'hF0. Required: next clk bit_idx=0, shreg=8'hF0, dout=1, frames unchanged.
- Reset mid-frame at bit_idx=3. Required: next clk all outputs at reset values; subsequent step pulses produce no change until load.
- Pattern change mid-frame: load 8'h81, change pattern to 8'h00 before any step. Required: transmitted bits stay 1,0,0,0,0,0,0,1.
